// File: rtl/sram_bist_master_if.sv
// SRAM request/acknowledge bus between the BIST master and the 16x4 SRAM port.
// Requests are single-cycle pulses; each is acknowledged one cycle later.
interface sram_bist_master_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 4
);
   logic                  write;
   logic                  read;
   logic [ADDR_WIDTH-1:0] write_addr;
   logic [ADDR_WIDTH-1:0] read_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  wr_done;
   logic                  rd_done;

   modport master (
      output write, read, write_addr, read_addr, wr_data,
      input  rd_data, wr_done, rd_done
   );

   modport slave (
      input  write, read, write_addr, read_addr, wr_data,
      output rd_data, wr_done, rd_done
   );
endinterface

// File: rtl/sram_bist_master.sv
// SRAM BIST master: pattern write / read-verify bursts over a wrapping range, 2 cycles per word.
// Waits up to TIMEOUT cycles per acknowledge, then aborts the burst and flags timeout_err.
module sram_bist_master #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 4,
   parameter int TIMEOUT    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            mode,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   len,
   input  logic [DATA_WIDTH-1:0] seed,
   sram_bist_master_if.master    sram,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   err_count,
   output logic [ADDR_WIDTH-1:0] first_err_addr,
   output logic [DATA_WIDTH-1:0] first_err_data,
   output logic                  timeout_err
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0]         WAIT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0]         WAIT_ONE  = CW'(1);
   localparam logic [ADDR_WIDTH:0]   LEFT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDLE,
      WR_ISSUE,
      WR_WAIT,
      RD_ISSUE,
      RD_WAIT,
      FINISH
   } state_t;

   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] word_addr, addr_nx;
   logic [ADDR_WIDTH:0]   words_left, left_nx;
   logic [CW-1:0]         wait_cnt, wait_nx;
   logic [1:0]            cmd_mode;
   logic [ADDR_WIDTH-1:0] cmd_base;
   logic [ADDR_WIDTH:0]   cmd_len;
   logic [DATA_WIDTH-1:0] cmd_seed;

   logic                  accept;
   logic                  mismatch;
   logic                  timeout_hit;
   logic [DATA_WIDTH-1:0] pat_seed;
   logic                  pat_inv;
   logic [DATA_WIDTH-1:0] wr_pat_nx;
   logic [DATA_WIDTH-1:0] rd_expect;

   logic                  write_q, read_q;
   logic [ADDR_WIDTH-1:0] write_addr_q, read_addr_q;
   logic [DATA_WIDTH-1:0] wr_data_q;

   assign sram.write      = write_q;
   assign sram.read       = read_q;
   assign sram.write_addr = write_addr_q;
   assign sram.read_addr  = read_addr_q;
   assign sram.wr_data    = wr_data_q;

   function automatic logic [DATA_WIDTH-1:0] pattern(
      input logic [ADDR_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] s,
      input logic                  inv
   );
      logic [DATA_WIDTH-1:0] p;
      p = DATA_WIDTH'(a) ^ s;
      return inv ? ~p : p;
   endfunction

   // The first write data is registered in the same edge the command is captured.
   assign pat_seed  = accept ? seed : cmd_seed;
   assign pat_inv   = accept ? (mode == 2'b11) : (cmd_mode == 2'b11);
   assign wr_pat_nx = pattern(addr_nx, pat_seed, pat_inv);
   assign rd_expect = pattern(word_addr, cmd_seed, cmd_mode == 2'b11);

   always_comb begin
      state_nx    = state;
      addr_nx     = word_addr;
      left_nx     = words_left;
      wait_nx     = wait_cnt;
      accept      = 1'b0;
      mismatch    = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               addr_nx = base_addr;
               left_nx = len;
               if (len == '0)
                  state_nx = FINISH;
               else if (mode == 2'b01)
                  state_nx = RD_ISSUE;
               else
                  state_nx = WR_ISSUE;
            end
         end
         WR_ISSUE: begin
            state_nx = WR_WAIT;
            wait_nx  = '0;
         end
         WR_WAIT: begin
            if (sram.wr_done) begin
               if (words_left > LEFT_ONE) begin
                  left_nx  = words_left - LEFT_ONE;
                  addr_nx  = word_addr + ADDR_ONE;
                  state_nx = WR_ISSUE;
               end else if (cmd_mode[1]) begin
                  left_nx  = cmd_len;
                  addr_nx  = cmd_base;
                  state_nx = RD_ISSUE;
               end else begin
                  state_nx = FINISH;
               end
            end else if (wait_cnt == WAIT_LAST) begin
               timeout_hit = 1'b1;
               state_nx    = FINISH;
            end else begin
               wait_nx = wait_cnt + WAIT_ONE;
            end
         end
         RD_ISSUE: begin
            state_nx = RD_WAIT;
            wait_nx  = '0;
         end
         RD_WAIT: begin
            if (sram.rd_done) begin
               mismatch = (sram.rd_data != rd_expect);
               if (words_left > LEFT_ONE) begin
                  left_nx  = words_left - LEFT_ONE;
                  addr_nx  = word_addr + ADDR_ONE;
                  state_nx = RD_ISSUE;
               end else begin
                  state_nx = FINISH;
               end
            end else if (wait_cnt == WAIT_LAST) begin
               timeout_hit = 1'b1;
               state_nx    = FINISH;
            end else begin
               wait_nx = wait_cnt + WAIT_ONE;
            end
         end
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         word_addr      <= '0;
         words_left     <= '0;
         wait_cnt       <= '0;
         cmd_mode       <= '0;
         cmd_base       <= '0;
         cmd_len        <= '0;
         cmd_seed       <= '0;
         write_q        <= 1'b0;
         read_q         <= 1'b0;
         write_addr_q   <= '0;
         read_addr_q    <= '0;
         wr_data_q      <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
         first_err_data <= '0;
         timeout_err    <= 1'b0;
      end else begin
         state      <= state_nx;
         word_addr  <= addr_nx;
         words_left <= left_nx;
         wait_cnt   <= wait_nx;
         // Outputs are decoded from the next state so they line up with it.
         write_q    <= (state_nx == WR_ISSUE);
         read_q     <= (state_nx == RD_ISSUE);
         busy       <= state_nx inside {WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT};
         done       <= (state_nx == FINISH);
         if (state_nx == WR_ISSUE) begin
            write_addr_q <= addr_nx;
            wr_data_q    <= wr_pat_nx;
         end
         if (state_nx == RD_ISSUE)
            read_addr_q <= addr_nx;
         if (accept) begin
            cmd_mode       <= mode;
            cmd_base       <= base_addr;
            cmd_len        <= len;
            cmd_seed       <= seed;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            timeout_err    <= 1'b0;
         end
         if (mismatch) begin
            if (err_count == '0) begin
               first_err_addr <= word_addr;
               first_err_data <= sram.rd_data;
            end
            if (err_count != '1)
               err_count <= err_count + LEFT_ONE;
         end
         if (timeout_hit)
            timeout_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sram_bist_master.sv
// Directed bench for sram_bist_master with a one-cycle-latency SRAM responder.
// Each command is traced per cycle (cycle 1 = first cycle after the start edge).
module tb_sram_bist_master;
   localparam int AW = 4;
   localparam int DW = 4;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [1:0]    mode;
   logic [AW-1:0] base_addr;
   logic [AW:0]   len;
   logic [DW-1:0] seed;
   logic          busy, done, timeout_err;
   logic [AW:0]   err_count;
   logic [AW-1:0] first_err_addr;
   logic [DW-1:0] first_err_data;

   always #5 clk = ~clk;

   sram_bist_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) sif ();

   sram_bist_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .mode           (mode),
      .base_addr      (base_addr),
      .len            (len),
      .seed           (seed),
      .sram           (sif.master),
      .busy           (busy),
      .done           (done),
      .err_count      (err_count),
      .first_err_addr (first_err_addr),
      .first_err_data (first_err_data),
      .timeout_err    (timeout_err)
   );

   logic [DW-1:0] mem [0:15];
   logic          no_wr_ack;

   always @(posedge clk) begin
      sif.wr_done <= sif.write && !no_wr_ack;
      sif.rd_done <= sif.read;
      if (sif.write) mem[sif.write_addr] <= sif.wr_data;
      if (sif.read)  sif.rd_data <= mem[sif.read_addr];
   end

   int n_vec  = 0;
   int n_miss = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   int            wr_n, rd_n, both_n, done_n, done_cyc;
   logic [AW-1:0] wa[$];
   logic [DW-1:0] wd[$];
   int            wc[$];
   logic [AW-1:0] ra[$];

   task automatic run(input logic [1:0] m, input logic [AW-1:0] b, input logic [AW:0] l,
                      input logic [DW-1:0] s, input int poke_cyc, input int rst_cyc, input int budget);
      wr_n = 0; rd_n = 0; both_n = 0; done_n = 0; done_cyc = -1;
      wa.delete(); wd.delete(); wc.delete(); ra.delete();
      @(negedge clk);
      start = 1'b1; mode = m; base_addr = b; len = l; seed = s;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= budget; k++) begin
         @(negedge clk);
         if (sif.write) begin
            wr_n++; wa.push_back(sif.write_addr); wd.push_back(sif.wr_data); wc.push_back(k);
         end
         if (sif.read) begin
            rd_n++; ra.push_back(sif.read_addr);
         end
         if (sif.write && sif.read) both_n++;
         if (done) begin
            done_n++;
            if (done_cyc < 0) done_cyc = k;
         end
         if (k == poke_cyc) begin
            start = 1'b1; mode = 2'b01; base_addr = 4'd9; len = 5'd1;
         end
         if (k == poke_cyc + 1) start = 1'b0;
         if (k == rst_cyc) begin
            chk("rst_pre_write", sif.write, 1);
            rst = 1'b1;
            #1;
            chk("rst_drop", {sif.write, sif.read, busy, done}, 0);
            #1 rst = 1'b0;
            break;
         end
         if (done_cyc > 0 && k >= done_cyc + 1) break;
      end
   endtask

   initial begin
      logic [DW-1:0] exp_d2 [4];
      logic [DW-1:0] exp_d3 [3];
      logic [AW-1:0] ea;
      exp_d2 = '{4'h4, 4'h5, 4'hA, 4'hB};
      exp_d3 = '{4'hB, 4'h8, 4'h9};

      rst = 1'b1; start = 1'b0; mode = 2'b00; base_addr = '0; len = '0; seed = '0;
      no_wr_ack = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ctrl", {busy, done, sif.write, sif.read, timeout_err}, 0);
      chk("reset_err", err_count, 0);
      chk("reset_first", {first_err_addr, first_err_data}, 0);
      @(negedge clk) rst = 1'b0;

      // full-range write, seed 0
      run(2'b00, 4'd0, 5'd16, 4'h0, 0, 0, 60);
      chk("m00_wr_n", wr_n, 16);
      for (int i = 0; i < 16; i++) begin
         chk("m00_addr", wa[i], i);
         chk("m00_data", wd[i], i);
         chk("m00_wcyc", wc[i], 2 * i + 1);
      end
      chk("m00_rd_n", rd_n, 0);
      chk("m00_done_cyc", done_cyc, 33);
      chk("m00_done_n", done_n, 1);
      chk("m00_busy", busy, 0);
      chk("m00_both", both_n, 0);

      // write-then-verify wrapping 15 -> 0
      run(2'b10, 4'd14, 5'd4, 4'hA, 0, 0, 60);
      chk("m10_wr_n", wr_n, 4);
      chk("m10_rd_n", rd_n, 4);
      for (int i = 0; i < 4; i++) begin
         ea = 4'd14 + 4'(i);
         chk("m10_waddr", wa[i], ea);
         chk("m10_wdata", wd[i], exp_d2[i]);
         chk("m10_raddr", ra[i], ea);
      end
      chk("m10_err", err_count, 0);
      chk("m10_done_cyc", done_cyc, 17);
      chk("m10_both", both_n, 0);

      // inverted pattern
      run(2'b11, 4'd5, 5'd3, 4'h1, 0, 0, 60);
      for (int i = 0; i < 3; i++) chk("m11_wdata", wd[i], exp_d3[i]);
      chk("m11_err", err_count, 0);
      chk("m11_done_cyc", done_cyc, 13);

      // read-verify against a corrupted word
      run(2'b00, 4'd0, 5'd8, 4'h5, 0, 0, 60);
      mem[3] = 4'h0;
      run(2'b01, 4'd0, 5'd8, 4'h5, 0, 0, 60);
      chk("m01_err", err_count, 1);
      chk("m01_first_addr", first_err_addr, 3);
      chk("m01_first_data", first_err_data, 0);
      chk("m01_rd_n", rd_n, 8);
      chk("m01_wr_n", wr_n, 0);
      chk("m01_done_cyc", done_cyc, 17);

      // write acknowledge withheld
      no_wr_ack = 1'b1;
      run(2'b00, 4'd0, 5'd4, 4'h0, 0, 0, 40);
      no_wr_ack = 1'b0;
      chk("to_flag", timeout_err, 1);
      chk("to_wr_n", wr_n, 1);
      chk("to_done_n", done_n, 1);
      chk("to_done_cyc", done_cyc, 10);
      chk("to_busy", busy, 0);

      // zero-length command clears status
      run(2'b10, 4'd7, 5'd0, 4'h3, 0, 0, 20);
      chk("len0_done_cyc", done_cyc, 1);
      chk("len0_rw", wr_n + rd_n, 0);
      chk("len0_to_clr", timeout_err, 0);
      chk("len0_err", err_count, 0);

      // start pulsed while busy
      run(2'b00, 4'd2, 5'd4, 4'h0, 2, 0, 40);
      chk("poke_wr_n", wr_n, 4);
      for (int i = 0; i < 4; i++) chk("poke_addr", wa[i], i + 2);
      chk("poke_rd_n", rd_n, 0);
      chk("poke_done_cyc", done_cyc, 9);
      chk("poke_done_n", done_n, 1);

      // async reset mid-burst, then a clean rerun
      run(2'b10, 4'd0, 5'd4, 4'h3, 0, 5, 60);
      chk("rst_done_n", done_n, 0);
      repeat (2) @(negedge clk);
      chk("rst_idle", {busy, done, sif.write, sif.read}, 0);
      run(2'b10, 4'd0, 5'd4, 4'h3, 0, 0, 60);
      chk("rerun_err", err_count, 0);
      chk("rerun_rd_n", rd_n, 4);
      chk("rerun_done_cyc", done_cyc, 17);
      chk("rerun_to", timeout_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/sram_bist_master.md
Name: sram_bist_master

Overview:
- Initiator for the 16x4 SRAM read/write port; drives read, write, write_addr, read_addr and wr_data, and consumes rd_data, wr_done and rd_done.
- Runs a commanded burst: pattern write, read-verify, or write-then-verify over a wrapping address range.
- Reports the error count, first failing address/data, and a timeout.
- Sits between the test/control logic and the SRAM instance.

Parameters:
ADDR_WIDTH, 4, SRAM address width
DATA_WIDTH, 4, SRAM data width
TIMEOUT, 8, max cycles waited for wr_done/rd_done before abort (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  command strobe, sampled only in IDLE
mode  in  2  00 write, 01 read-verify, 10 write-then-verify, 11 write-then-verify inverted pattern
base_addr  in  ADDR_WIDTH  first address
len  in  ADDR_WIDTH+1  word count, 0..16
seed  in  DATA_WIDTH  pattern seed
write  out  1  SRAM write request
read  out  1  SRAM read request
write_addr  out  ADDR_WIDTH  SRAM write address
read_addr  out  ADDR_WIDTH  SRAM read address
wr_data  out  DATA_WIDTH  SRAM write data
rd_data  in  DATA_WIDTH  SRAM read data, valid with rd_done
wr_done  in  1  SRAM write acknowledge, one cycle after write
rd_done  in  1  SRAM read acknowledge, one cycle after read
busy  out  1  command in progress
done  out  1  one-cycle completion pulse
err_count  out  ADDR_WIDTH+1  verify mismatches, saturating at all-ones
first_err_addr  out  ADDR_WIDTH  address of first mismatch
first_err_data  out  DATA_WIDTH  data read at first mismatch
timeout_err  out  1  acknowledge not received within TIMEOUT

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; internal counters 0. Reset mid-burst abandons the burst with no done pulse.
- All outputs are registered. write and read are never high in the same cycle.
- Pattern: expected(a) = a[DATA_WIDTH-1:0] ^ seed. Mode 11 uses the bitwise inverse.
- Address of word i = (base_addr + i) mod 2^ADDR_WIDTH; wraps 15 -> 0.
- States: IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, FINISH.
- IDLE:
  - start=1 with len=0 -> FINISH, with status cleared.
  - start=1 with len>0 -> captures the command, clears err_count, first_err_*, timeout_err; sets busy=1.
  - Goes to WR_ISSUE for modes 00/10/11, RD_ISSUE for mode 01.
- start while busy is ignored.
- WR_ISSUE: write=1 for exactly one cycle with write_addr/wr_data = current word -> WR_WAIT.
- WR_WAIT: write=0.
  - On wr_done=1: advance word. If more words -> WR_ISSUE.
  - If last word: modes 10/11 restart the word index at base -> RD_ISSUE; mode 00 -> FINISH.
- RD_ISSUE: read=1 for one cycle with read_addr = current word -> RD_WAIT.
- RD_WAIT: on rd_done=1, compare rd_data with expected.
  - Mismatch: err_count+1 (saturating). The first mismatch also captures first_err_addr/first_err_data.
  - Then advance: more words -> RD_ISSUE, else FINISH.
- Wait counter:
  - Cleared on entry to WR_WAIT/RD_WAIT; increments each cycle without an acknowledge.
  - Reaching TIMEOUT sets timeout_err=1 and goes to FINISH; remaining words are skipped.
- Acknowledges arriving outside WR_WAIT/RD_WAIT are ignored.
- FINISH: done=1 for one cycle, busy=0 -> IDLE. Status outputs hold until the next accepted start.
- Throughput: 2 cycles per word.
  - Start sampled at edge 0 → write high in cycles 1,3,…,2N-1 → done high in cycle 2N+1 (mode 00).
  - Mode 10/11 with a well-behaved SRAM: done in cycle 4N+1.

Test Plan:
- Mode 00, base=0, len=16, seed=0 -> 16 single-cycle write pulses, addr 0..15, data 0..15; done in cycle 33; read never high.
- Mode 10, base=14, len=4, seed=4'hA -> writes to 14,15,0,1 with data 4,5,A,B; reads back; err_count=0; done in cycle 17.
- Mode 01 after a forced corrupt of addr 3 to 4'h0, base=0, len=8, seed=4'h5 -> err_count=1, first_err_addr=3, first_err_data=0.
- Responder withholding wr_done after the first write, TIMEOUT=8 -> timeout_err=1, done pulse, write pulses=1, busy=0.
- len=0 with start -> done in the next cycle, no read/write; start pulsed while busy mid-burst -> no effect on addresses or count.
- rst asserted asynchronously mid mode-10 burst -> write/read/busy/done drop immediately; a new start afterwards runs cleanly with err_count=0.
